// File: rtl/video_timing_gen.sv
// Runtime-reconfigurable raster timing generator: hs/vs/de, pixel coordinates,
// line/frame strobes and a fixed-depth delayed sync copy, with frame-aligned config shadowing.
module video_timing_gen #(
  parameter int unsigned CW         = 12,
  parameter int unsigned DELAY      = 5,
  parameter int unsigned DEF_H_SYNC = 136,
  parameter int unsigned DEF_H_BP   = 160,
  parameter int unsigned DEF_H_ACT  = 1024,
  parameter int unsigned DEF_H_FP   = 24,
  parameter int unsigned DEF_V_SYNC = 6,
  parameter int unsigned DEF_V_BP   = 29,
  parameter int unsigned DEF_V_ACT  = 768,
  parameter int unsigned DEF_V_FP   = 3,
  parameter bit          DEF_HS_POL = 1'b0,
  parameter bit          DEF_VS_POL = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          cfg_load,
  input  logic [CW-1:0] cfg_h_sync,
  input  logic [CW-1:0] cfg_h_bp,
  input  logic [CW-1:0] cfg_h_act,
  input  logic [CW-1:0] cfg_h_fp,
  input  logic [CW-1:0] cfg_v_sync,
  input  logic [CW-1:0] cfg_v_bp,
  input  logic [CW-1:0] cfg_v_act,
  input  logic [CW-1:0] cfg_v_fp,
  input  logic          cfg_hs_pol,
  input  logic          cfg_vs_pol,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic [CW-1:0] active_x,
  output logic [CW-1:0] active_y,
  output logic          line_start,
  output logic          frame_start,
  output logic          cfg_busy,
  output logic          hs_d,
  output logic          vs_d,
  output logic          de_d
);

  localparam int unsigned SW = CW + 2;

  typedef struct packed {
    logic [CW-1:0] h_sync;
    logic [CW-1:0] h_bp;
    logic [CW-1:0] h_act;
    logic [CW-1:0] h_fp;
    logic [CW-1:0] v_sync;
    logic [CW-1:0] v_bp;
    logic [CW-1:0] v_act;
    logic [CW-1:0] v_fp;
    logic          hs_pol;
    logic          vs_pol;
  } cfg_t;

  localparam cfg_t DEF_CFG = '{
    h_sync: CW'(DEF_H_SYNC), h_bp: CW'(DEF_H_BP), h_act: CW'(DEF_H_ACT), h_fp: CW'(DEF_H_FP),
    v_sync: CW'(DEF_V_SYNC), v_bp: CW'(DEF_V_BP), v_act: CW'(DEF_V_ACT), v_fp: CW'(DEF_V_FP),
    hs_pol: DEF_HS_POL, vs_pol: DEF_VS_POL
  };

  function automatic cfg_t clamp(input cfg_t c);
    cfg_t r;
    r = c;
    if (r.h_sync == '0) r.h_sync = CW'(1);
    if (r.h_bp   == '0) r.h_bp   = CW'(1);
    if (r.h_act  == '0) r.h_act  = CW'(1);
    if (r.h_fp   == '0) r.h_fp   = CW'(1);
    if (r.v_sync == '0) r.v_sync = CW'(1);
    if (r.v_bp   == '0) r.v_bp   = CW'(1);
    if (r.v_act  == '0) r.v_act  = CW'(1);
    if (r.v_fp   == '0) r.v_fp   = CW'(1);
    return r;
  endfunction

  cfg_t act_cfg, pend_cfg, cfg_in;
  logic [SW-1:0] h_cnt, v_cnt;
  logic [SW-1:0] h_start, h_end, h_total, v_start, v_end, v_total;
  logic          h_last, v_last, frame_end, h_win, v_win, de_n;

  always_comb begin
    cfg_in = '{
      h_sync: cfg_h_sync, h_bp: cfg_h_bp, h_act: cfg_h_act, h_fp: cfg_h_fp,
      v_sync: cfg_v_sync, v_bp: cfg_v_bp, v_act: cfg_v_act, v_fp: cfg_v_fp,
      hs_pol: cfg_hs_pol, vs_pol: cfg_vs_pol
    };
    h_start   = SW'(act_cfg.h_sync) + SW'(act_cfg.h_bp);
    h_end     = h_start + SW'(act_cfg.h_act);
    h_total   = h_end + SW'(act_cfg.h_fp);
    v_start   = SW'(act_cfg.v_sync) + SW'(act_cfg.v_bp);
    v_end     = v_start + SW'(act_cfg.v_act);
    v_total   = v_end + SW'(act_cfg.v_fp);
    // >= rather than == so an out-of-range count can never run away
    h_last    = (h_cnt >= h_total - SW'(1));
    v_last    = (v_cnt >= v_total - SW'(1));
    frame_end = enable && h_last && v_last;
    h_win     = (h_cnt >= h_start) && (h_cnt < h_end);
    v_win     = (v_cnt >= v_start) && (v_cnt < v_end);
    de_n      = h_win && v_win;
  end

  // A load landing on the frame-end cycle bypasses the shadow and applies at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_cfg  <= DEF_CFG;
      pend_cfg <= '0;
      cfg_busy <= 1'b0;
    end else if (frame_end) begin
      if (cfg_load) begin
        act_cfg  <= clamp(cfg_in);
        pend_cfg <= cfg_in;
      end else if (cfg_busy) begin
        act_cfg  <= clamp(pend_cfg);
      end
      cfg_busy <= 1'b0;
    end else if (cfg_load) begin
      pend_cfg <= cfg_in;
      cfg_busy <= 1'b1;
    end else if (!enable && cfg_busy) begin
      act_cfg  <= clamp(pend_cfg);
      cfg_busy <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!enable) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + SW'(1);
    end else begin
      h_cnt <= h_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs          <= ~DEF_HS_POL;
      vs          <= ~DEF_VS_POL;
      de          <= 1'b0;
      active_x    <= '0;
      active_y    <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (!enable) begin
      hs          <= ~act_cfg.hs_pol;
      vs          <= ~act_cfg.vs_pol;
      de          <= 1'b0;
      active_x    <= '0;
      active_y    <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hs          <= (h_cnt < SW'(act_cfg.h_sync)) ? act_cfg.hs_pol : ~act_cfg.hs_pol;
      vs          <= (v_cnt < SW'(act_cfg.v_sync)) ? act_cfg.vs_pol : ~act_cfg.vs_pol;
      de          <= de_n;
      active_x    <= de_n ? CW'(h_cnt - h_start) : '0;
      active_y    <= de_n ? CW'(v_cnt - v_start) : '0;
      line_start  <= (h_cnt == '0);
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

  generate
    if (DELAY == 0) begin : g_nodly
      assign hs_d = hs;
      assign vs_d = vs;
      assign de_d = de;
    end else begin : g_dly
      localparam logic [2:0] INACT = {~DEF_HS_POL, ~DEF_VS_POL, 1'b0};
      logic [2:0] dly [DELAY];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned i = 0; i < DELAY; i++) dly[i] <= INACT;
        end else begin
          dly[0] <= {hs, vs, de};
          for (int unsigned i = 1; i < DELAY; i++) dly[i] <= dly[i-1];
        end
      end
      assign {hs_d, vs_d, de_d} = dly[DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboarded random bench for video_timing_gen: a frame-position model predicts
// every output each clock; a negedge monitor compares against two DUT builds (DELAY 5 and 0).
module tb_video_timing_gen;

  localparam int DLY = 5;
  localparam int D_HS = 4, D_HB = 3, D_HA = 8, D_HF = 2;
  localparam int D_VS = 2, D_VB = 2, D_VA = 5, D_VF = 1;

  logic clk = 1'b1;
  logic rst = 1'b0;
  logic enable = 1'b0, cfg_load = 1'b0;
  logic [11:0] cfg_h_sync = '0, cfg_h_bp = '0, cfg_h_act = '0, cfg_h_fp = '0;
  logic [11:0] cfg_v_sync = '0, cfg_v_bp = '0, cfg_v_act = '0, cfg_v_fp = '0;
  logic cfg_hs_pol = 1'b0, cfg_vs_pol = 1'b0;

  logic hs, vs, de, line_start, frame_start, cfg_busy, hs_d, vs_d, de_d;
  logic [11:0] active_x, active_y;
  logic hs0, vs0, de0, ls0, fs0, busy0, hs_d0, vs_d0, de_d0;
  logic [11:0] ax0, ay0;

  always #5 clk = ~clk;

  video_timing_gen #(.CW(12), .DELAY(DLY),
    .DEF_H_SYNC(D_HS), .DEF_H_BP(D_HB), .DEF_H_ACT(D_HA), .DEF_H_FP(D_HF),
    .DEF_V_SYNC(D_VS), .DEF_V_BP(D_VB), .DEF_V_ACT(D_VA), .DEF_V_FP(D_VF),
    .DEF_HS_POL(1'b0), .DEF_VS_POL(1'b0)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_load(cfg_load),
    .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp), .cfg_h_act(cfg_h_act), .cfg_h_fp(cfg_h_fp),
    .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp), .cfg_v_act(cfg_v_act), .cfg_v_fp(cfg_v_fp),
    .cfg_hs_pol(cfg_hs_pol), .cfg_vs_pol(cfg_vs_pol),
    .hs(hs), .vs(vs), .de(de), .active_x(active_x), .active_y(active_y),
    .line_start(line_start), .frame_start(frame_start), .cfg_busy(cfg_busy),
    .hs_d(hs_d), .vs_d(vs_d), .de_d(de_d));

  video_timing_gen #(.CW(12), .DELAY(0),
    .DEF_H_SYNC(D_HS), .DEF_H_BP(D_HB), .DEF_H_ACT(D_HA), .DEF_H_FP(D_HF),
    .DEF_V_SYNC(D_VS), .DEF_V_BP(D_VB), .DEF_V_ACT(D_VA), .DEF_V_FP(D_VF),
    .DEF_HS_POL(1'b0), .DEF_VS_POL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .cfg_load(cfg_load),
    .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp), .cfg_h_act(cfg_h_act), .cfg_h_fp(cfg_h_fp),
    .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp), .cfg_v_act(cfg_v_act), .cfg_v_fp(cfg_v_fp),
    .cfg_hs_pol(cfg_hs_pol), .cfg_vs_pol(cfg_vs_pol),
    .hs(hs0), .vs(vs0), .de(de0), .active_x(ax0), .active_y(ay0),
    .line_start(ls0), .frame_start(fs0), .cfg_busy(busy0),
    .hs_d(hs_d0), .vs_d(vs_d0), .de_d(de_d0));

  typedef struct {
    int hsw, hb, ha, hf, vsw, vb, va, vf, hp, vp;
  } mcfg_t;

  typedef struct {
    int hs, vs, de, ax, ay, ls, fs, busy, hsd, vsd, ded;
  } exp_t;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  logic [2:0] hist[$];

  mcfg_t cur, pend;
  int busy_m, pos, last_de;

  function automatic mcfg_t def_cfg();
    mcfg_t c;
    c = '{D_HS, D_HB, D_HA, D_HF, D_VS, D_VB, D_VA, D_VF, 0, 0};
    return c;
  endfunction

  function automatic int atleast1(int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic mcfg_t mclamp(mcfg_t c);
    mcfg_t r;
    r = '{atleast1(c.hsw), atleast1(c.hb), atleast1(c.ha), atleast1(c.hf),
          atleast1(c.vsw), atleast1(c.vb), atleast1(c.va), atleast1(c.vf), c.hp, c.vp};
    return r;
  endfunction

  function automatic int htot(mcfg_t c);
    return c.hsw + c.hb + c.ha + c.hf;
  endfunction

  function automatic int flen(mcfg_t c);
    return htot(c) * (c.vsw + c.vb + c.va + c.vf);
  endfunction

  // Raster position is a single index into the frame; line and pixel fall out by division.
  function automatic exp_t raster(mcfg_t c, int p);
    exp_t e;
    int h, v, hin, vin;
    h = p % htot(c);
    v = p / htot(c);
    hin = (h >= c.hsw + c.hb) && (h < c.hsw + c.hb + c.ha);
    vin = (v >= c.vsw + c.vb) && (v < c.vsw + c.vb + c.va);
    e = '{default: 0};
    e.hs = (h < c.hsw) ? c.hp : 1 - c.hp;
    e.vs = (v < c.vsw) ? c.vp : 1 - c.vp;
    e.de = hin && vin;
    e.ax = e.de ? h - (c.hsw + c.hb) : 0;
    e.ay = e.de ? v - (c.vsw + c.vb) : 0;
    e.ls = (h == 0);
    e.fs = (p == 0);
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    exp_t e;
    mcfg_t cin;
    logic [2:0] t;
    if (rst) begin
      cur = def_cfg();
      pend = '{default: 0};
      busy_m = 0;
      pos = 0;
      last_de = 0;
      e = '{default: 0};
      e.hs = 1; e.vs = 1; e.hsd = 1; e.vsd = 1;
      hist.delete();
      for (int i = 0; i <= DLY; i++) hist.push_back(3'b110);
      exp_q.delete();
      exp_q.push_back(e);
    end else begin
      cin = '{int'(cfg_h_sync), int'(cfg_h_bp), int'(cfg_h_act), int'(cfg_h_fp),
              int'(cfg_v_sync), int'(cfg_v_bp), int'(cfg_v_act), int'(cfg_v_fp),
              int'(cfg_hs_pol), int'(cfg_vs_pol)};
      if (enable) begin
        e = raster(cur, pos);
        if (pos == flen(cur) - 1) begin
          pos = 0;
          if (cfg_load) begin
            cur = mclamp(cin);
            pend = cin;
          end else if (busy_m) begin
            cur = mclamp(pend);
          end
          busy_m = 0;
        end else begin
          pos = pos + 1;
          if (cfg_load) begin
            pend = cin;
            busy_m = 1;
          end
        end
      end else begin
        e = '{default: 0};
        e.hs = 1 - cur.hp;
        e.vs = 1 - cur.vp;
        pos = 0;
        if (cfg_load) begin
          pend = cin;
          busy_m = 1;
        end else if (busy_m) begin
          cur = mclamp(pend);
          busy_m = 0;
        end
      end
      e.busy = busy_m;
      t = {e.hs[0], e.vs[0], e.de[0]};
      hist.push_back(t);
      void'(hist.pop_front());
      t = hist[0];
      e.hsd = t[2]; e.vsd = t[1]; e.ded = t[0];
      last_de = e.de;
      exp_q.push_back(e);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0d expected=%0d", nm, $time, act, expv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("hs", 32'(hs), e.hs);
      chk("vs", 32'(vs), e.vs);
      chk("de", 32'(de), e.de);
      chk("active_x", 32'(active_x), e.ax);
      chk("active_y", 32'(active_y), e.ay);
      chk("line_start", 32'(line_start), e.ls);
      chk("frame_start", 32'(frame_start), e.fs);
      chk("cfg_busy", 32'(cfg_busy), e.busy);
      chk("hs_d", 32'(hs_d), e.hsd);
      chk("vs_d", 32'(vs_d), e.vsd);
      chk("de_d", 32'(de_d), e.ded);
      chk("hs_nodelay", 32'(hs0), e.hs);
      chk("de_nodelay", 32'(de0), e.de);
      chk("active_x_nodelay", 32'(ax0), e.ax);
      chk("frame_start_nodelay", 32'(fs0), e.fs);
      chk("hs_d_nodelay", 32'(hs_d0), e.hs);
      chk("vs_d_nodelay", 32'(vs_d0), e.vs);
      chk("de_d_nodelay", 32'(de_d0), e.de);
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cfg(input int a, b, c, d, e, f, g, h, input int hp, vp);
    cfg_h_sync = 12'(a); cfg_h_bp = 12'(b); cfg_h_act = 12'(c); cfg_h_fp = 12'(d);
    cfg_v_sync = 12'(e); cfg_v_bp = 12'(f); cfg_v_act = 12'(g); cfg_v_fp = 12'(h);
    cfg_hs_pol = hp[0]; cfg_vs_pol = vp[0];
  endtask

  task automatic rand_cfg();
    set_cfg($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 5),
            $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(0, 4),
            $urandom_range(0, 1), $urandom_range(0, 1));
  endtask

  task automatic pulse_load();
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  task automatic load_at_frame_end();
    int n;
    n = 0;
    while (!(enable && pos == flen(cur) - 1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL frame_end_wait: actual=timeout required=frame end within 3000 clocks");
    end else begin
      pulse_load();
    end
  endtask

  initial begin
    #2 rst = 1'b1;
    run(3);
    rst = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    run(2 * 170 + 20);

    // mid-frame reconfiguration with flipped polarities
    run(50);
    set_cfg(4, 3, 10, 3, 2, 1, 6, 2, 1, 1);
    pulse_load();
    run(3 * 300);

    // back-to-back loads: last one wins
    rand_cfg();
    pulse_load();
    set_cfg(2, 2, 5, 1, 1, 2, 3, 1, 0, 1);
    pulse_load();
    run(500);

    // load on the exact frame-end cycle, with a zero active width
    set_cfg(2, 1, 0, 1, 1, 1, 3, 1, 0, 0);
    load_at_frame_end();
    run(200);

    // enable dropped mid-line, then re-raised
    run(7);
    enable = 1'b0;
    run(10);
    enable = 1'b1;
    run(200);

    // config loaded while idle
    enable = 1'b0;
    rand_cfg();
    pulse_load();
    run(5);
    enable = 1'b1;
    run(300);

    for (int it = 0; it < 60; it++) begin
      int act;
      run($urandom_range(1, 150));
      act = $urandom_range(0, 9);
      if (act < 4) begin
        rand_cfg();
        pulse_load();
      end else if (act == 4) begin
        enable = 1'b0;
        run($urandom_range(1, 20));
        if ($urandom_range(0, 1) == 1) begin
          rand_cfg();
          pulse_load();
        end
        enable = 1'b1;
      end else if (act == 5) begin
        rand_cfg();
        load_at_frame_end();
      end
    end

    // asynchronous reset during an active line after a custom config
    set_cfg(3, 2, 7, 2, 1, 2, 4, 1, 1, 1);
    pulse_load();
    run(400);
    begin
      int n;
      n = 0;
      while (!last_de && n < 2000) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n >= 2000) begin
        errors++;
        $display("FAIL wait_de: actual=timeout required=de within 2000 clocks");
      end
    end
    @(posedge clk);
    #2 rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(400);

    checks++;
    if (checks < 1000) begin
      errors++;
      $display("FAIL check_volume: actual=%0d required>=1000", checks);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: actual=timeout required=bench completion");
    $fatal(1, "timeout");
  end

endmodule
